// File: rtl/rom_fetch_arbiter.sv
// Two-port arbiter in front of the single-port instruction ROM: fixed priority to fetch,
// starvation escape for the debug/loader port, registered one-cycle response pulses.
module rom_fetch_arbiter #(
   parameter int unsigned InstAddrWidth = 32,
   parameter int unsigned InstDataWidth = 32,
   parameter int unsigned InstMemNum    = 32,
   parameter int unsigned StarveLimit   = 4,
   parameter int unsigned CntWidth      = 3
) (
   input  logic                     clk,
   input  logic                     rst,

   input  logic                     m0_req,
   input  logic [InstAddrWidth-1:0] m0_addr,
   output logic                     m0_gnt,
   output logic                     m0_rvalid,
   output logic [InstDataWidth-1:0] m0_rdata,
   output logic                     m0_rerr,

   input  logic                     m1_req,
   input  logic [InstAddrWidth-1:0] m1_addr,
   output logic                     m1_gnt,
   output logic                     m1_rvalid,
   output logic [InstDataWidth-1:0] m1_rdata,
   output logic                     m1_rerr,

   output logic                     if_stall,

   output logic                     rom_ce,
   output logic [InstAddrWidth-1:0] rom_addr,
   input  logic [InstDataWidth-1:0] rom_inst
);

   localparam logic [CntWidth-1:0]      StarveMax = CntWidth'(StarveLimit);
   localparam logic [InstAddrWidth-1:0] MemWords  = InstAddrWidth'(InstMemNum);

   logic [CntWidth-1:0]      starve_cnt_q, starve_cnt_d;
   logic                     m0_rvalid_q, m0_rvalid_d;
   logic [InstDataWidth-1:0] m0_rdata_q, m0_rdata_d;
   logic                     m0_rerr_q, m0_rerr_d;
   logic                     m1_rvalid_q, m1_rvalid_d;
   logic [InstDataWidth-1:0] m1_rdata_q, m1_rdata_d;
   logic                     m1_rerr_q, m1_rerr_d;

   logic                     force1;
   logic                     win0, win1;
   logic [InstAddrWidth-1:0] win_addr;
   logic                     misaligned, out_of_range, bad;

   // Grants are suppressed while reset is held so nothing reaches the ROM.
   always_comb begin
      force1 = m1_req & (starve_cnt_q == StarveMax);
      win0   = 1'b0;
      win1   = 1'b0;
      if (rst) begin
         if (force1) begin
            win1 = 1'b1;
         end else if (m0_req) begin
            win0 = 1'b1;
         end else if (m1_req) begin
            win1 = 1'b1;
         end
      end
   end

   always_comb begin
      win_addr     = win1 ? m1_addr : m0_addr;
      misaligned   = (win_addr[1:0] != 2'b00);
      out_of_range = ({2'b00, win_addr[InstAddrWidth-1:2]} >= MemWords);
      bad          = misaligned | out_of_range;
   end

   assign m0_gnt   = win0;
   assign m1_gnt   = win1;
   assign if_stall = rst & m0_req & ~win0;
   assign rom_ce   = (win0 | win1) & ~bad;
   assign rom_addr = rom_ce ? win_addr : '0;

   always_comb begin
      m0_rvalid_d = win0;
      m0_rdata_d  = m0_rdata_q;
      m0_rerr_d   = m0_rerr_q;
      m1_rvalid_d = win1;
      m1_rdata_d  = m1_rdata_q;
      m1_rerr_d   = m1_rerr_q;
      if (win0) begin
         m0_rdata_d = bad ? '0 : rom_inst;
         m0_rerr_d  = bad;
      end
      if (win1) begin
         m1_rdata_d = bad ? '0 : rom_inst;
         m1_rerr_d  = bad;
      end
   end

   // Counts consecutive denied cycles of m1; any grant or dropped request restarts it.
   always_comb begin
      starve_cnt_d = '0;
      if (m1_req & ~win1) begin
         starve_cnt_d = (starve_cnt_q == StarveMax) ? starve_cnt_q : starve_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_cnt_q <= '0;
         m0_rvalid_q  <= 1'b0;
         m0_rdata_q   <= '0;
         m0_rerr_q    <= 1'b0;
         m1_rvalid_q  <= 1'b0;
         m1_rdata_q   <= '0;
         m1_rerr_q    <= 1'b0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         m0_rvalid_q  <= m0_rvalid_d;
         m0_rdata_q   <= m0_rdata_d;
         m0_rerr_q    <= m0_rerr_d;
         m1_rvalid_q  <= m1_rvalid_d;
         m1_rdata_q   <= m1_rdata_d;
         m1_rerr_q    <= m1_rerr_d;
      end
   end

   assign m0_rvalid = m0_rvalid_q;
   assign m0_rdata  = m0_rdata_q;
   assign m0_rerr   = m0_rerr_q;
   assign m1_rvalid = m1_rvalid_q;
   assign m1_rdata  = m1_rdata_q;
   assign m1_rerr   = m1_rerr_q;

endmodule
